// File: rtl/logic_reduce_pkg.sv
// Shared types and constants for the logic_reduce_pipe block.
package logic_reduce_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_NOR = 2'd3
    } op_e;

    localparam int STATS_W = 16;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        if (v == {STATS_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(STATS_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/logic_reduce_core.sv
// Combinational bitwise reduction of NUM_IN channels of WIDTH bits under a selectable op.
module logic_reduce_core
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  op_e                     op,
    output logic [WIDTH-1:0]        result
);

    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] xor_s;

    // Fold all channels together under each operator, then pick one.
    always_comb begin
        or_s  = '0;
        and_s = '1;
        xor_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            or_s  = or_s  | data[i*WIDTH +: WIDTH];
            and_s = and_s & data[i*WIDTH +: WIDTH];
            xor_s = xor_s ^ data[i*WIDTH +: WIDTH];
        end
        case (op)
            OP_OR:   result = or_s;
            OP_AND:  result = and_s;
            OP_XOR:  result = xor_s;
            OP_NOR:  result = ~or_s;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Two-stage valid/ready pipeline reducing NUM_IN channels bitwise.
// Define LOGIC_REDUCE_STATS_EN to add the saturating beat_count output.
module logic_reduce_pipe
    import logic_reduce_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int NUM_IN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef LOGIC_REDUCE_STATS_EN
    ,
    output logic [STATS_W-1:0]      beat_count
`endif
);

    logic                    s1_valid_q, s1_valid_d;
    logic [NUM_IN*WIDTH-1:0] s1_data_q,  s1_data_d;
    op_e                     s1_op_q,    s1_op_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]        s2_data_q,  s2_data_d;
    logic                    s2_zero_q,  s2_zero_d;
    logic                    s1_load_s;
    logic                    s2_load_s;
    logic [WIDTH-1:0]        core_result_s;

    logic_reduce_core #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_core (
        .data   (s1_data_q),
        .op     (s1_op_q),
        .result (core_result_s)
    );

    // Load enables and next-state for both stages; payloads hold unless a valid beat moves in.
    always_comb begin
        s2_load_s  = !s2_valid_q || out_ready;
        s1_load_s  = !s1_valid_q || s2_load_s;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_zero_d  = s2_zero_q;
        if (s1_load_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_op_d   = op_e'(in_op);
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = core_result_s;
                s2_zero_d = (core_result_s == '0);
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset leaves an empty pipe with a zero result on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_op_q    <= OP_OR;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign in_ready  = s1_load_s;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_zero  = s2_zero_q;

`ifdef LOGIC_REDUCE_STATS_EN
    logic [STATS_W-1:0] beat_count_q;

    // Count output handshakes, sticking at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            beat_count_q <= sat_inc(beat_count_q);
        end else begin
            beat_count_q <= beat_count_q;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Randomized scoreboard bench for logic_reduce_pipe (WIDTH=3, NUM_IN=3).
module tb_logic_reduce_pipe;

    localparam int W = 3;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [1:0]     in_op;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_zero;
    logic           out_valid;
    logic           out_ready;
`ifdef LOGIC_REDUCE_STATS_EN
    logic [15:0]    beat_count;
`endif

    logic_reduce_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LOGIC_REDUCE_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: per bit position, count how many channels have that bit set.
    function automatic logic [W-1:0] model(input logic [N*W-1:0] d, input logic [1:0] op);
        logic [W-1:0] r;
        r = '0;
        for (int b = 0; b < W; b++) begin
            int cnt = 0;
            for (int c = 0; c < N; c++) cnt += int'(d[c*W + b]);
            case (op)
                2'd0:    r[b] = (cnt > 0);
                2'd1:    r[b] = (cnt == N);
                2'd2:    r[b] = (cnt % 2 == 1);
                default: r[b] = (cnt == 0);
            endcase
        end
        return r;
    endfunction

    // One cycle of stimulus; the handshake is judged at the falling edge.
    task automatic drive(input bit v, input logic [N*W-1:0] d, input logic [1:0] op,
                         input bit ordy, input bit r, input bit use_exp,
                         input logic [W-1:0] ed, input bit lat, output bit acc);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_op     = op;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        acc = 1'b0;
        if (r) begin
            q.delete();
        end else if (v && in_ready) begin
            acc   = 1'b1;
            e.d   = use_exp ? ed : model(d, op);
            e.z   = (e.d == '0);
            e.cyc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N*W-1:0] d, input logic [1:0] op, input bit ordy,
                        input bit use_exp, input logic [W-1:0] ed, input bit lat);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            drive(1'b1, d, op, ordy, 1'b0, use_exp, ed, lat, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
        chk("queue_drained", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        bit acc;
        drive(1'b1, 9'h1FF, 2'd1, 1'b0, 1'b1, 1'b0, '0, 1'b0, acc);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready",  in_ready,  32'd1);
        chk("rst_out_zero",  out_zero,  32'd1);
        chk("rst_out_data",  out_data,  32'd0);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold during stalls.
    initial begin
        bit           hold_v;
        logic [W-1:0] hold_d;
        logic         hold_z;
        exp_t         e;
        hold_v = 1'b0;
        hold_d = '0;
        hold_z = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("stall_valid", out_valid, 32'd1);
                    chk("stall_data",  out_data,  hold_d);
                    chk("stall_zero",  out_zero,  hold_z);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got out_data=%0h with no beat outstanding (cycle %0d)",
                                 out_data, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_zero", out_zero, e.z);
                        if (e.lat) chk("latency", cyc, e.cyc + 2);
                    end
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data;
                hold_z = out_zero;
            end
        end
    end

    initial begin
        bit            acc;
        int            nacc;
        int            k;
        logic [N*W-1:0] bp[3];

        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 2'd0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Single OR beat, channels c0=100 c1=000 c2=000.
        send({3'b000, 3'b000, 3'b100}, 2'd0, 1'b1, 1'b1, 3'b100, 1'b1);
        drain(4);

        // AND then XOR on consecutive cycles; XOR result is zero.
        send({3'b111, 3'b111, 3'b111}, 2'd1, 1'b1, 1'b1, 3'b111, 1'b1);
        send({3'b011, 3'b010, 3'b001}, 2'd2, 1'b1, 1'b1, 3'b000, 1'b1);
        // NOR of c0=000 c1=010 c2=001.
        send({3'b001, 3'b010, 3'b000}, 2'd3, 1'b1, 1'b1, 3'b100, 1'b1);
        drain(4);

        // Backpressure: four cycles of in_valid with out_ready low.
        bp[0] = {3'b101, 3'b110, 3'b011};
        bp[1] = {3'b001, 3'b001, 3'b111};
        bp[2] = {3'b010, 3'b100, 3'b110};
        k = 0;
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bp[k], 2'(k), 1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
            if (acc) begin
                nacc++;
                k++;
            end
        end
        chk("bp_accepted", nacc, 32'd2);
        chk("bp_in_ready", in_ready, 32'd0);
        send(bp[2], 2'd2, 1'b1, 1'b0, '0, 1'b0);
        drain(5);

        // Reset with two beats in flight; the handshake on the reset edge is dropped.
        send({3'b111, 3'b000, 3'b101}, 2'd0, 1'b0, 1'b0, '0, 1'b0);
        send({3'b010, 3'b011, 3'b110}, 2'd1, 1'b0, 1'b0, '0, 1'b0);
        do_reset();
        drain(6);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 9'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) == 0),
                  1'b0, '0, 1'b0, acc);
        end
        drain(6);

`ifdef LOGIC_REDUCE_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) send(9'($urandom), 2'($urandom), 1'b1, 1'b0, '0, 1'b0);
        drain(5);
        chk("beat_count_5", beat_count, 32'd5);
        do_reset();
        chk("beat_count_rst", beat_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
